// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder slice.
//   - scancode constants (break prefix, extended prefix, six game keys)
//   - frame FSM state enum
//   - key index constants and a scancode -> key index lookup
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam int NUM_KEYS  = 6;
  localparam int KEY_W     = 0;
  localparam int KEY_S     = 1;
  localparam int KEY_D     = 2;
  localparam int KEY_A     = 3;
  localparam int KEY_SPACE = 4;
  localparam int KEY_ESC   = 5;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_lookup_t;

  function automatic key_lookup_t key_lookup(input logic [7:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = '0;
    case (code)
      SC_W:     r.idx = 3'(KEY_W);
      SC_S:     r.idx = 3'(KEY_S);
      SC_D:     r.idx = 3'(KEY_D);
      SC_A:     r.idx = 3'(KEY_A);
      SC_SPACE: r.idx = 3'(KEY_SPACE);
      SC_ESC:   r.idx = 3'(KEY_ESC);
      default:  r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle between the keyboard/CPU side and the key decoder.
//   ps2_clk, ps2_data : raw PS/2 lines (asynchronous)
//   keyboard_reset    : one-cycle pulse, clears every sticky bit
//   *_out             : {14'b0, sticky, held} per key
//   frame_err         : one-cycle pulse on a discarded frame
// master = stimulus/CPU side, slave = decoder.
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic        keyboard_reset;
  logic [15:0] forward_out;
  logic [15:0] backward_out;
  logic [15:0] turnright_out;
  logic [15:0] turnleft_out;
  logic [15:0] shoot_out;
  logic [15:0] reset_out;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data, keyboard_reset,
    input  forward_out, backward_out, turnright_out, turnleft_out,
           shoot_out, reset_out, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, keyboard_reset,
    output forward_out, backward_out, turnright_out, turnleft_out,
           shoot_out, reset_out, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, frame FSM
// (start, 8 data LSB-first, odd parity, stop) and inactivity timeout.
//   clk, reset     : system clock, synchronous active-high reset
//   ps2_clk/data   : raw keyboard lines
//   rx_byte        : received byte, stable while byte_valid is high
//   byte_valid     : one-cycle pulse, cycle after the stop-bit edge
//   frame_err      : one-cycle pulse on bad start/parity/stop or timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall;

  frame_state_e state, state_nxt;
  logic [7:0]   shreg, shreg_nxt;
  logic [2:0]   bit_cnt, bit_cnt_nxt;
  logic         par_bit, par_nxt;
  logic [TW-1:0] tmo_cnt;
  logic         tmo_hit;
  logic         bv_nxt, fe_nxt;

  // Idle-high lines: flops reset to 1 so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync[0]  <= ps2_clk;
      data_sync[0] <= ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
      clk_prev <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  // Counts edge-free cycles inside a frame; the TIMEOUT_CYCLES-th one aborts.
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt >= TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset || fall || state == IDLE) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_MAX)        tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      par_bit    <= par_nxt;
      byte_valid <= bv_nxt;
      frame_err  <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par_bit;
    bv_nxt      = 1'b0;
    fe_nxt      = 1'b0;
    if (tmo_hit) begin
      state_nxt = IDLE;
      fe_nxt    = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            fe_nxt = 1'b1;
          end
        end
        DATA: begin
          shreg_nxt   = {data_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = data_s;
          state_nxt = STOP;
        end
        STOP: begin
          // Odd parity: data plus parity bit must XOR to 1.
          if (data_s && (^{shreg, par_bit})) bv_nxt = 1'b1;
          else                               fe_nxt = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shift register is untouched in STOP/IDLE, so it holds the byte.
  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder for six game keys (W, S, D, A, Space, Esc).
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of ps2_key_decoder_if (PS/2 lines,
//                keyboard_reset, six key outputs, frame_err)
// held follows make/break; sticky latches on make until keyboard_reset.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_decoder_if.slave   bus
);

  logic [7:0] rx_byte;
  logic       byte_valid;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (bus.frame_err)
  );

  logic [NUM_KEYS-1:0] held, held_nxt, sticky, sticky_nxt;
  logic                break_pend, brk_nxt, ext_pend, ext_nxt;
  key_lookup_t         lk;

  assign lk = key_lookup(rx_byte);

  // keyboard_reset clears first so a same-cycle make still lands its sticky.
  always_comb begin
    held_nxt   = held;
    sticky_nxt = bus.keyboard_reset ? '0 : sticky;
    brk_nxt    = break_pend;
    ext_nxt    = ext_pend;
    if (byte_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk_nxt = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_nxt = 1'b1;
      end else begin
        brk_nxt = 1'b0;
        ext_nxt = 1'b0;
        if (lk.hit && !ext_pend) begin
          if (break_pend) begin
            held_nxt[lk.idx] = 1'b0;
          end else begin
            held_nxt[lk.idx]   = 1'b1;
            sticky_nxt[lk.idx] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held       <= '0;
      sticky     <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      held       <= held_nxt;
      sticky     <= sticky_nxt;
      break_pend <= brk_nxt;
      ext_pend   <= ext_nxt;
    end
  end

  assign bus.forward_out   = {14'b0, sticky[KEY_W],     held[KEY_W]};
  assign bus.backward_out  = {14'b0, sticky[KEY_S],     held[KEY_S]};
  assign bus.turnright_out = {14'b0, sticky[KEY_D],     held[KEY_D]};
  assign bus.turnleft_out  = {14'b0, sticky[KEY_A],     held[KEY_A]};
  assign bus.shoot_out     = {14'b0, sticky[KEY_SPACE], held[KEY_SPACE]};
  assign bus.reset_out     = {14'b0, sticky[KEY_ESC],   held[KEY_ESC]};

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, is the clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 Parameter SYNC_STAGES, default 2, is the flip-flop depth of the ps2_clk/ps2_data synchronisers.
REQ-003 Port clk, input, 1: single system clock; all logic on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port ps2_clk, input, 1: raw keyboard clock, asynchronous to clk.
REQ-006 Port ps2_data, input, 1: raw keyboard data, asynchronous to clk.
REQ-007 Port keyboard_reset, input, 1: one-cycle pulse from the memory controller on a CPU write to any key address; clears all sticky bits.
REQ-008 Ports forward_out, backward_out, turnright_out, turnleft_out, shoot_out, reset_out, output, 16 each: {14'b0, sticky, held} for W, S, D, A, Space, Esc.
REQ-009 Port frame_err, output, 1: one-cycle pulse on a discarded frame (bad start, parity, stop or timeout).

Function
REQ-010 ps2_clk and ps2_data SHALL pass through SYNC_STAGES flops; a falling edge is synchronised ps2_clk 1 then 0 on consecutive cycles.
REQ-011 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP, and every transition SHALL occur only on a detected falling edge, except timeout.
REQ-012 IDLE: sampled data 0 -> DATA with bit count 0; sampled data 1 -> stay IDLE, pulse frame_err.
REQ-013 DATA: shift sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-014 PARITY: record bit; -> STOP.
REQ-015 STOP: if stop = 1 and the 8 data bits plus parity have odd weight, issue a one-cycle byte_valid; otherwise pulse frame_err; -> IDLE in both cases.
REQ-016 If not in IDLE and TIMEOUT_CYCLES clk cycles pass without a falling edge, the FSM SHALL go to IDLE, pulse frame_err and emit no byte.
REQ-017 The timeout counter SHALL clear on every falling edge and SHALL saturate, never wrap.
REQ-018 Byte decoder, on byte_valid: 0xF0 sets break_pend; 0xE0 sets ext_pend; any other byte is a key code and clears both pend flags after use.
REQ-019 A key code with ext_pend=0 SHALL map as follows: 0x1D W, 0x1B S, 0x23 D, 0x1C A, 0x29 Space, 0x76 Esc.
REQ-020 A key code with ext_pend=1, or any unmapped code, SHALL change no key state.
REQ-021 For a mapped key with break_pend=0 (make), held SHALL be set and sticky SHALL be set.
REQ-022 For a mapped key with break_pend=1 (break), held SHALL be cleared and sticky SHALL be left unchanged.
REQ-023 Repeated make codes (typematic) SHALL be idempotent.
REQ-024 keyboard_reset SHALL clear all six sticky bits next cycle and SHALL leave held bits unchanged.
REQ-025 If keyboard_reset and a make for key K occur in the same cycle, K's sticky SHALL end set and all other sticky bits SHALL end clear.
REQ-026 Outputs SHALL be registered; a key update SHALL be visible on the outputs the cycle after byte_valid, which is 1 cycle after the stop-bit edge is detected.
REQ-027 Output bits 15:2 SHALL always be 0.

Reset
REQ-028 While reset is high, the FSM SHALL be in IDLE, and the shift register, bit count, timeout counter, break_pend, ext_pend, all held and sticky bits, every *_out, and frame_err SHALL all be 0; synchroniser flops SHALL be 1.
REQ-029 A reset arriving mid-frame SHALL abandon the frame without a frame_err pulse; the next start bit SHALL begin a fresh frame.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the scancode constants (F0, E0, the six key codes), the frame-FSM state enum and the key index constants.
REQ-031 Sub-module ps2_rx_frame SHALL contain the synchronisers, the frame FSM and the timeout, and SHALL output byte, byte_valid and frame_err.
REQ-032 The parent SHALL contain the byte decoder and the key registers.

Verification
REQ-033 Frame 0x1D with valid parity -> forward_out = 16'h0003, all other key outputs = 0.
REQ-034 Sequence 0x1D, 0xF0, 0x1D -> forward_out = 16'h0002; then a keyboard_reset pulse -> forward_out = 16'h0000.
REQ-035 Sequence 0xE0, 0x1D -> all outputs unchanged; then 0x29 -> shoot_out = 16'h0003, proving ext_pend cleared.
REQ-036 Frame 0x76 with bad parity -> one frame_err pulse, reset_out = 0; the following good 0x76 -> reset_out = 16'h0003.
REQ-037 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; a following 0x1C frame -> turnleft_out = 16'h0003.
REQ-038 keyboard_reset in the same cycle as byte_valid for 0x23, with W already sticky -> turnright_out = 16'h0003, forward_out = 16'h0001.
